// File: rtl/byte_mux_arbiter_pkg.sv
// Shared constants and state encoding for the four-requester byte arbiter.
package byte_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/byte_mux_arbiter_if.sv
// Bus between four byte requesters, the arbiter and one downstream byte consumer.
interface byte_mux_arbiter_if;
    import byte_mux_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] last;
    logic [DATA_W-1:0]  in0;
    logic [DATA_W-1:0]  in1;
    logic [DATA_W-1:0]  in2;
    logic [DATA_W-1:0]  in3;
    logic               out_ready;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] ack;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               abort;

    // Handshake: a byte transfers in every cycle where out_valid && out_ready.
    // out_valid never depends on out_ready; it mirrors the granted req, so it
    // may drop without a transfer when that requester stalls. ack marks the
    // transfer back to the granted requester in the same cycle.
    modport master (
        output req, last, in0, in1, in2, in3, out_ready,
        input  out_valid, out_data, gnt, ack, sel, busy, abort
    );

    modport slave (
        input  req, last, in0, in1, in2, in3, out_ready,
        output out_valid, out_data, gnt, ack, sel, busy, abort
    );

endinterface

// File: rtl/byte_mux_arbiter_mux4by1.sv
// Plain 8-bit 4:1 byte multiplexer; sel 0..3 picks in0..in3.
module mux4by1
    import byte_mux_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/byte_mux_arbiter.sv
// Round-robin burst arbiter sharing one mux4by1 among four byte requesters,
// with a beat cap for fairness and a stall timeout that aborts idle grants.
module byte_mux_arbiter
    import byte_mux_arbiter_pkg::*;
#(
    parameter int MAX_BEATS     = 16,
    parameter int STALL_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    byte_mux_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [BW-1:0]      BEAT_LAST  = BW'(MAX_BEATS - 1);
    localparam logic [SW-1:0]      STALL_LAST = SW'(STALL_TIMEOUT - 1);
    localparam logic [BW-1:0]      BEAT_ONE   = BW'(1);
    localparam logic [SW-1:0]      STALL_ONE  = SW'(1);
    localparam logic [SEL_W-1:0]   SEL_ONE    = SEL_W'(1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

    state_t             state;
    logic [NUM_REQ-1:0] gnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   pick;
    logic [BW-1:0]      beat_cnt;
    logic [SW-1:0]      stall_cnt;
    logic               abort_q;
    logic               cur_req;
    logic               cur_last;
    logic               accept;

    // First set request at or after p, wrapping; the descending loop lets the
    // smallest offset overwrite later ones.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        rr_pick = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = p + SEL_W'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign pick     = rr_pick(bus.req, ptr_q);
    assign cur_req  = bus.req[sel_q];
    assign cur_last = bus.last[sel_q];

    assign bus.out_valid = (state == ST_GRANT) && cur_req;
    assign accept        = bus.out_valid && bus.out_ready;
    assign bus.ack       = accept ? (ONE_HOT0 << sel_q) : '0;
    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state == ST_GRANT);
    assign bus.abort     = abort_q;

    mux4by1 u_mux (
        .in0 (bus.in0),
        .in1 (bus.in1),
        .in2 (bus.in2),
        .in3 (bus.in3),
        .sel (sel_q),
        .out (bus.out_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state     <= ST_GRANT;
                        gnt_q     <= ONE_HOT0 << pick;
                        sel_q     <= pick;
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        stall_cnt <= '0;
                        if (cur_last || (beat_cnt == BEAT_LAST)) begin
                            state    <= ST_IDLE;
                            gnt_q    <= '0;
                            ptr_q    <= sel_q + SEL_ONE;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_ONE;
                        end
                    end else if (cur_req) begin
                        // Backpressure only: requester is still present.
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_LAST) begin
                        state     <= ST_IDLE;
                        gnt_q     <= '0;
                        ptr_q     <= sel_q + SEL_ONE;
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                        abort_q   <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/byte_mux_arbiter.md
Name: byte_mux_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit 4:1 byte multiplexer (mux4by1) among four requesters.
- Grants one requester at a time for a burst of beats and drives the mux select.
- Presents the selected byte to a single downstream consumer with a valid/ready handshake.
- Used wherever four byte sources feed one byte sink in the Hunter_RV32 datapath, e.g. the debug/UART byte path or store-byte staging.

Parameters:
- MAX_BEATS, 16: fairness cap. The grant is force-released after this many accepted beats, even if last is never seen.
- STALL_TIMEOUT, 8: consecutive cycles the granted requester may hold req low mid-burst before the grant is aborted.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  request from requester i (bit i)
- last  input  4  final-beat marker from requester i; sampled only on an accepted beat
- in0  input  8  byte from requester 0
- in1  input  8  byte from requester 1
- in2  input  8  byte from requester 2
- in3  input  8  byte from requester 3
- out_ready  input  1  consumer can accept a byte this cycle
- out_valid  output  1  out_data is valid
- out_data  output  8  selected byte (mux4by1 output)
- gnt  output  4  one-hot grant, registered
- ack  output  4  beat accepted from requester i, combinational
- sel  output  2  current mux select, registered
- busy  output  1  high in GRANT state
- abort  output  1  one-cycle pulse when a grant is aborted by stall timeout

Behaviour:
- One clock (clk). rst is asynchronous, active-high. Asserting rst forces all registers immediately, without a clock edge.
- Reset values:
  - state=IDLE, gnt=0000, sel=00, ptr=00, beat_cnt=0, stall_cnt=0, abort=0.
  - out_valid=0, busy=0, ack=0000.
  - out_data follows in0, because sel=00.
- States: IDLE and GRANT.
- IDLE:
  - gnt=0, out_valid=0.
  - If req!=0, pick the first set bit searching from ptr upward, mod 4.
  - On that edge register gnt (one-hot), sel=index, beat_cnt=0, stall_cnt=0; go to GRANT.
  - Latency: req seen at edge n gives gnt/out_valid at cycle n+1.
- GRANT (cur = sel):
  - out_valid = req[cur]; out_data = in[cur] through mux4by1.
  - Accepted beat when out_valid & out_ready: ack[cur]=1 in the same cycle, beat_cnt increments, stall_cnt clears.
  - Release when an accepted beat has last[cur]=1, or beat_cnt+1 == MAX_BEATS. On that edge: state=IDLE, gnt=0, ptr=cur+1 mod 4.
  - Every release passes through IDLE, giving one bubble cycle between grants.
- Backpressure: while out_ready=0, out_data, sel, gnt and beat_cnt hold. No ack. stall_cnt does not advance while req[cur]=1.
- Stall abort:
  - While req[cur]=0, stall_cnt increments each cycle.
  - On reaching STALL_TIMEOUT: go to IDLE, gnt=0, ptr=cur+1, abort=1 for exactly one cycle.
  - req[cur] returning high clears stall_cnt.
- last with req[cur]=0 is ignored. last in IDLE is ignored.
- Non-granted requesters never see ack. Their req changes have no effect until IDLE.
- If release and a new req arrive in the same cycle, the new req is arbitrated in the following IDLE cycle using the updated ptr.
- Counter widths: beat_cnt is clog2(MAX_BEATS+1) bits; stall_cnt is clog2(STALL_TIMEOUT+1) bits. Neither wraps, because release occurs before overflow.
- sel encoding: 00 selects in0, 01 in1, 10 in2, 11 in3.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NUM_REQ=4 and DATA_W=8 constants.
- One sub-module: mux4by1, instantiated unchanged, with sel driving its select.
- The round-robin priority pick stays as a function inside byte_mux_arbiter.

Test Plan:
- Reset, req=0001, last[0] on the 3rd beat, out_ready=1:
  - gnt=0001 and sel=00 one cycle after req.
  - Exactly 3 ack[0] pulses, out_data=in0 each beat.
  - Then IDLE for one cycle, with ptr=1.
- req=1111 held, last=1111, out_ready=1:
  - gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Each grant is one beat, separated by one bubble cycle.
- Granted requester 2, in2=8'hA5, out_ready low for 5 cycles:
  - out_valid=1 and out_data=8'hA5 held throughout, ack=0000, beat_cnt unchanged.
  - Ready high gives one ack[2].
- MAX_BEATS=4, req=0011, last never asserted:
  - Grant to requester 0 released after the 4th ack.
  - Next grant goes to requester 1, sel=01.
- STALL_TIMEOUT=8, granted requester drops req for 8 cycles:
  - abort high for exactly one cycle, gnt=0000, out_valid=0.
  - ptr advances past the stalled requester.
- rst asserted mid-burst between clock edges:
  - gnt=0000, out_valid=0, busy=0, sel=00 immediately.
  - After release, arbitration restarts from requester 0.
